pipe_skid32: RTL and testbench

Two-entry elastic pipeline register (skid buffer) carrying a 32-bit word between two RISC-V pipeline stages with a valid/ready handshake on both sides. It is the consuming-side counterpart of the plain load-enable stage register. Stalls come from downstream via `out_ready`. `in_ready` is a pure decode of state, so there is no combinational ready path through the block. Full throughput is one word per cycle, and a synchronous flush supports branch/exception squash.

---
 rtl/pipe_pkg.sv | 8 +
 rtl/dreg_en_n.sv | 20 ++
 rtl/pipe_skid32.sv | 103 ++++++++++
 tb/tb_pipe_skid32.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and widths for the two-entry skid pipeline register.
package pipe_pkg;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t;

    localparam int PIPE_W = 32;

endpackage

// File: rtl/dreg_en_n.sv
// WIDTH-bit register with load enable and asynchronous active-low clear.
module dreg_en_n #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid32.sv
// Two-entry elastic pipeline register; ready and valid decode from state only.
module pipe_skid32
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = PIPE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_t      state_q;
    skid_state_t      state_d;
    logic             main_ld;
    logic             skid_ld;
    logic             main_from_skid;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_fire;
    logic             out_fire;

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_data  = main_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and register load selection; flush overrides everything.
    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        skid_ld        = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_ld = 1'b1;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_ld = 1'b1;
                end else if (in_fire) begin
                    skid_ld = 1'b1;
                    state_d = TWO;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        if (flush) begin
            state_d        = EMPTY;
            main_ld        = 1'b0;
            skid_ld        = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    dreg_en_n #(.WIDTH(WIDTH)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (main_ld),
        .d     (main_d),
        .q     (main_q)
    );

    dreg_en_n #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (skid_ld),
        .d     (in_data),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_pipe_skid32.sv
// Directed bench for pipe_skid32 against a queue-based model of the buffer.
module tb_pipe_skid32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] q[$];
    logic [31:0] consumed[$];

    pipe_skid32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a FIFO of at most two words; outputs follow from its occupancy.
    always @(negedge clk) begin
        logic ifire;
        logic ofire;
        if (!rst_n) begin
            q.delete();
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_data", out_data, 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
        end else begin
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (q.size() != 0) chk("out_data", out_data, q[0]);
            ifire = in_valid && (q.size() < 2);
            ofire = out_ready && (q.size() != 0);
            if (ofire) consumed.push_back(q.pop_front());
            if (flush) q.delete();
            else if (ifire) q.push_back(in_data);
        end
    end

    task automatic cyc(input logic v, input logic [31:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_log(input string name, input logic [31:0] exp[$]);
        chk({name, "_len"}, 32'(consumed.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < consumed.size(); i++) begin
            chk(name, consumed[i], exp[i]);
        end
        consumed.delete();
    endtask

    initial begin
        logic [31:0] exp[$];

        #12;
        chk("init_out_valid", 32'(out_valid), 32'd0);
        chk("init_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_out_data", out_data, 32'd0);
        consumed.delete();

        // Streaming, one word per cycle.
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 32'(i), 1'b1, 1'b0);
            chk("stream_latency", out_data, 32'(i));
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        exp = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8};
        expect_log("stream_order", exp);

        // Stall absorbs one extra word into the skid register.
        cyc(1'b1, 32'hA0, 1'b1, 1'b0);
        cyc(1'b1, 32'hA1, 1'b1, 1'b0);
        cyc(1'b1, 32'hA2, 1'b0, 1'b0);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_head", out_data, 32'hA1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        chk("stall_hold_ready", 32'(in_ready), 32'd0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("recover_in_ready", 32'(in_ready), 32'd1);
        chk("recover_head", out_data, 32'hA2);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        exp = '{32'hA0, 32'hA1, 32'hA2};
        expect_log("stall_order", exp);

        // Flush while full.
        cyc(1'b1, 32'hB0, 1'b0, 1'b0);
        cyc(1'b1, 32'hB1, 1'b0, 1'b0);
        chk("b_full_ready", 32'(in_ready), 32'd0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        exp = {};
        expect_log("flush_drop", exp);

        // Flush coinciding with an accept drops the word.
        cyc(1'b1, 32'hC0, 1'b1, 1'b1);
        chk("flush_in_out_valid", 32'(out_valid), 32'd0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        exp = {};
        expect_log("flush_in_drop", exp);

        // Asynchronous reset mid-stream.
        cyc(1'b1, 32'hD0, 1'b0, 1'b0);
        cyc(1'b1, 32'hD1, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data", out_data, 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 32'hD2, 1'b1, 1'b0);
        chk("post_rst_head", out_data, 32'hD2);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        exp = '{32'hD2};
        expect_log("post_rst_order", exp);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
